// File: rtl/ahb_ri5cy_ifetch.sv
// RI5CY instruction-fetch port to AHB-Lite read-only master bridge.
// One address slot and one data slot; a bus error pauses the queued address
// until the error's hready cycle and then re-presents it.
module ahb_ri5cy_ifetch #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // core instruction interface
    input  logic                      instr_req_i,
    input  logic [AHB_ADDR_WIDTH-1:0] instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    // AHB-Lite master
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]                htrans_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic                      hmastlock_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    input  logic                      hready_i,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      hresp_i
);

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    logic                      addr_vld_q, addr_vld_d;
    logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      data_vld_q, data_vld_d;
    logic                      err_q, err_d;
    logic                      addr_acc;
    logic                      gnt;

    // Word alignment drops the two low address bits.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^instr_addr_i[1:0];

    // Address phase completes only when the slave is ready and no error is pending.
    assign addr_acc = addr_vld_q & hready_i & ~err_q;
    // Gated by rst so the core sees no grant while reset is held.
    assign gnt      = instr_req_i & (~addr_vld_q | addr_acc) & ~rst;

    // Next-state for both slots and the error flag.
    always_comb begin
        addr_vld_d = addr_vld_q;
        addr_d     = addr_q;
        data_vld_d = data_vld_q;
        err_d      = err_q;

        if (gnt) begin
            addr_vld_d = 1'b1;
            addr_d     = {instr_addr_i[AHB_ADDR_WIDTH-1:2], 2'b00};
        end else if (addr_acc) begin
            addr_vld_d = 1'b0;
        end

        if (hready_i) begin
            data_vld_d = addr_acc;
            err_d      = 1'b0;
        end else if (data_vld_q & hresp_i) begin
            // First cycle of a two-cycle ERROR: withdraw the pending address.
            err_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_vld_q <= 1'b0;
            addr_q     <= '0;
            data_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            addr_vld_q <= addr_vld_d;
            addr_q     <= addr_d;
            data_vld_q <= data_vld_d;
            err_q      <= err_d;
        end
    end

    // Core-side and AHB-side outputs.
    always_comb begin
        instr_gnt_o    = gnt;
        instr_rvalid_o = data_vld_q & hready_i;
        instr_rdata_o  = hrdata_i[31:0];
        instr_err_o    = data_vld_q & hready_i & hresp_i;
        haddr_o        = addr_q;
        htrans_o       = (addr_vld_q & ~err_q) ? HtransNonseq : HtransIdle;
        hwrite_o       = 1'b0;
        hsize_o        = 3'b010;
        hburst_o       = 3'b000;
        hprot_o        = 4'b0010;
        hmastlock_o    = 1'b0;
        hwdata_o       = '0;
    end

endmodule

// File: doc/ahb_ri5cy_ifetch.md
AHB_RI5CY_IFETCH -- requirements
Module: ahb_ri5cy_ifetch

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32, the AHB address width.
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 32, the AHB data width; only 32 is supported.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port instr_req_i  in  1  core fetch request.
REQ-006 SHALL have port instr_addr_i  in  AHB_ADDR_WIDTH  core fetch address.
REQ-007 SHALL have port instr_gnt_o  out  1  request accepted this cycle.
REQ-008 SHALL have port instr_rvalid_o  out  1  fetch response valid.
REQ-009 SHALL have port instr_rdata_o  out  32  fetched instruction word.
REQ-010 SHALL have port instr_err_o  out  1  response carries a bus error.
REQ-011 SHALL have port haddr_o  out  AHB_ADDR_WIDTH  AHB address, bits [1:0] always 0.
REQ-012 SHALL have port htrans_o  out  2  AHB transfer type: IDLE 2'b00 or NONSEQ 2'b10 only.
REQ-013 SHALL have ports hwrite_o (1), hsize_o (3), hburst_o (3), hprot_o (4), hmastlock_o (1), hwdata_o (AHB_DATA_WIDTH), all out, held constant at 0, 3'b010, 3'b000, 4'b0010, 0 and 0.
REQ-014 SHALL have port hready_i  in  1  AHB transfer-done.
REQ-015 SHALL have port hrdata_i  in  AHB_DATA_WIDTH  AHB read data.
REQ-016 SHALL have port hresp_i  in  1  AHB error response.

Function
REQ-017 SHALL keep three state elements: address slot (addr_vld, addr_q), data slot (data_vld), error flag err_q.
REQ-018 SHALL assert instr_gnt_o = instr_req_i & (~addr_vld | addr_acc), where addr_acc = addr_vld & hready_i & ~err_q.
REQ-019 SHALL, on gnt, load addr_q <= {instr_addr_i[AHB_ADDR_WIDTH-1:2],2'b00} and set addr_vld.
REQ-020 SHALL clear addr_vld on addr_acc without a simultaneous gnt; gnt and addr_acc together keep addr_vld = 1 and reload addr_q.
REQ-021 SHALL drive haddr_o = addr_q and htrans_o = NONSEQ when addr_vld & ~err_q, else htrans_o = IDLE.
REQ-022 SHALL hold haddr_o and htrans_o stable while hready_i = 0, except for the error cancel in REQ-027.
REQ-023 SHALL set data_vld <= addr_acc whenever hready_i = 1, and hold data_vld while hready_i = 0.
REQ-024 SHALL assert instr_rvalid_o = data_vld & hready_i (combinational), with instr_rdata_o = hrdata_i.
REQ-025 SHALL give a minimum latency of gnt at cycle N, NONSEQ at N+1, rvalid at N+2, and sustain one fetch per cycle with zero-wait slaves.
REQ-026 SHALL never have more than one address phase and one data phase outstanding.
REQ-027 SHALL, on the first error cycle (data_vld & hresp_i & ~hready_i), set err_q; while err_q = 1, htrans_o SHALL be IDLE and addr_vld/addr_q SHALL be retained.
REQ-028 SHALL clear err_q when hready_i = 1, and re-present the retained address as NONSEQ in the following cycle.
REQ-029 SHALL assert instr_err_o = instr_rvalid_o & hresp_i; instr_rdata_o content is don't-care on an error.
REQ-030 SHALL issue no gnt while err_q = 1 and the address slot is full.
REQ-031 SHALL accept an OKAY/hready_i=0 wait state of any length without dropping or duplicating a response.

Reset
REQ-032 SHALL, on rst = 1, immediately clear addr_vld, data_vld, err_q and addr_q, giving htrans_o = IDLE, haddr_o = 0, gnt/rvalid/err = 0.
REQ-033 SHALL, on rst asserted mid-transfer, discard in-flight fetches; no rvalid is produced for them after rst deasserts.
REQ-034 SHALL allow the first gnt in the first cycle after rst deasserts.

Verification
REQ-035 Single fetch, addr 0x80, zero-wait, hrdata 0x6f -> gnt at N, NONSEQ haddr 0x80 at N+1, rvalid with rdata 0x6f at N+2.
REQ-036 Back-to-back fetches 0x0, 0x4, 0x8 with req held -> gnt every cycle, three NONSEQs in consecutive cycles, three rvalids in consecutive cycles, in order.
REQ-037 Two wait states on the first data phase -> second NONSEQ (0x4) held stable for 3 cycles, rvalid for 0x0 only on the hready_i cycle, no extra gnt.
REQ-038 Two-cycle ERROR on 0x10 with 0x14 queued -> htrans IDLE in the second error cycle, instr_err_o on the hready cycle, 0x14 re-issued as NONSEQ next cycle and completes OKAY.
REQ-039 Misaligned addr 0x13 -> haddr_o 0x10.
REQ-040 rst pulsed during a stalled data phase -> all outputs return to reset values at once, no rvalid afterwards, and a new fetch after rst behaves as in REQ-035.
